// File: rtl/gate_array_pipe_if.sv
// Stream bundle for gate_array_pipe: input beat, op controls, registered output.
// The master side drives beats and out_ready; the slave side is the combiner.
interface gate_array_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [2:0]              op;
    logic                    acc_mode;
    logic                    acc_clear;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_any;

    modport master (
        output in_valid, in_data, op, acc_mode, acc_clear, out_ready,
        input  in_ready, out_valid, out_data, out_any
    );

    modport slave (
        input  in_valid, in_data, op, acc_mode, acc_clear, out_ready,
        output in_ready, out_valid, out_data, out_any
    );
endinterface

// File: rtl/gate_array_pipe.sv
// Registered NUM_IN-word bitwise combiner with optional sticky-OR framing
// over ACC_LEN beats and a valid/ready output register.
module gate_array_pipe #(
    parameter int WIDTH   = 8,
    parameter int NUM_IN  = 4,
    parameter int ACC_LEN = 4
) (
    input logic              clk,
    input logic              rst_n,
    gate_array_pipe_if.slave bus
);
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d, cur_cnt;
    logic [WIDTH-1:0] acc, acc_d, acc_next;
    logic [2:0]       op_q, cur_op;
    logic             cur_mode, start, accept, last;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] r_and, r_or, r_xor, g;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // A clear starts a fresh frame, so a coincident beat sees live controls.
    assign start    = (state == IDLE) || bus.acc_clear;
    assign cur_op   = start ? bus.op : op_q;
    assign cur_mode = start ? bus.acc_mode : 1'b1;
    assign cur_cnt  = start ? '0 : cnt;
    assign last     = (cur_cnt == CW'(ACC_LEN - 1));
    assign acc_next = (cur_cnt == '0) ? g : (acc | g);

    always_comb begin
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            r_and = r_and & bus.in_data[k*WIDTH +: WIDTH];
            r_or  = r_or  | bus.in_data[k*WIDTH +: WIDTH];
            r_xor = r_xor ^ bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        unique case (cur_op)
            3'd0:    g = r_and;
            3'd1:    g = r_or;
            3'd2:    g = r_xor;
            3'd3:    g = ~r_and;
            3'd4:    g = ~r_or;
            3'd5:    g = ~r_xor;
            default: g = r_or;
        endcase
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        acc_d     = acc;
        load      = 1'b0;
        load_data = g;
        if (bus.acc_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end
        if (accept) begin
            if (!cur_mode) begin
                load = 1'b1;
            end else if (last) begin
                state_d   = IDLE;
                cnt_d     = '0;
                acc_d     = acc_next;
                load      = 1'b1;
                load_data = acc_next;
            end else begin
                state_d = ACC;
                cnt_d   = cur_cnt + CW'(1);
                acc_d   = acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            op_q  <= 3'd1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            acc   <= acc_d;
            if (accept && start)
                op_q <= bus.op;
        end
    end

    // Drained data is held so downstream sees a stable word after valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_any   <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= load_data;
            bus.out_any   <= |load_data;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed bench for gate_array_pipe: driver pushes expected words into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_gate_array_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [8:0] exp_q[$];

    gate_array_pipe_if #(.WIDTH(8), .NUM_IN(4)) bus ();

    gate_array_pipe #(.WIDTH(8), .NUM_IN(4), .ACC_LEN(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h expected none",
                         bus.out_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("sb_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
                chk("sb_any", {31'd0, bus.out_any}, {31'd0, e[8]});
            end
        end
    end

    task automatic expect_out(input logic [7:0] d);
        exp_q.push_back({|d, d});
    endtask

    // Drives one beat; returns 1 time unit after the accepting edge.
    task automatic beat(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3,
                        input logic [2:0] o, input logic m, input logic c);
        int n;
        bus.in_data   = {w3, w2, w1, w0};
        bus.op        = o;
        bus.acc_mode  = m;
        bus.acc_clear = c;
        bus.in_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.acc_clear = 1'b0;
    endtask

    task automatic clear_only();
        bus.acc_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.op        = 3'd1;
        bus.acc_mode  = 1'b0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-frame with stale held data on the output
        expect_out(8'h87);
        beat(8'h01, 8'h02, 8'h04, 8'h80, 3'd1, 1'b0, 1'b0);
        beat(8'hFF, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'hFF, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("pre_rst_data", {24'd0, bus.out_data}, 32'h87);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_data", {24'd0, bus.out_data}, 32'd0);
        chk("async_rst_any", {31'd0, bus.out_any}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(8'h01, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'h02, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("post_rst_no_early", {31'd0, bus.out_valid}, 32'd0);
        beat(8'h04, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        expect_out(8'h0F);
        beat(8'h08, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("post_rst_frame", {31'd0, bus.out_valid}, 32'd1);

        // Pass mode, latency one cycle
        expect_out(8'h87);
        beat(8'h01, 8'h02, 8'h04, 8'h80, 3'd1, 1'b0, 1'b0);
        chk("pass_or_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pass_or_data", {24'd0, bus.out_data}, 32'h87);
        chk("pass_or_any", {31'd0, bus.out_any}, 32'd1);
        expect_out(8'h00);
        beat(8'hFF, 8'h0F, 8'hF0, 8'h00, 3'd2, 1'b0, 1'b0);
        expect_out(8'h01);
        beat(8'hFF, 8'hFF, 8'hFF, 8'hFE, 3'd3, 1'b0, 1'b0);
        expect_out(8'h01);
        beat(8'h01, 8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0);
        expect_out(8'h30);
        beat(8'hFF, 8'hF0, 8'h3C, 8'hFF, 3'd0, 1'b0, 1'b0);
        expect_out(8'hFE);
        beat(8'h00, 8'h00, 8'h00, 8'h01, 3'd4, 1'b0, 1'b0);
        expect_out(8'hFE);
        beat(8'h01, 8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
        expect_out(8'h01);
        beat(8'h01, 8'h00, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0);

        // Accumulate; mid-frame op/mode changes must be ignored
        beat(8'h01, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("acc_b1_quiet", {31'd0, bus.out_valid}, 32'd0);
        beat(8'h02, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        chk("acc_b2_quiet", {31'd0, bus.out_valid}, 32'd0);
        beat(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
        chk("acc_b3_quiet", {31'd0, bus.out_valid}, 32'd0);
        expect_out(8'h13);
        beat(8'h10, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("acc_b4_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("acc_b4_data", {24'd0, bus.out_data}, 32'h13);

        // Backpressure, then drain and load in one edge
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        expect_out(8'h0F);
        beat(8'hFF, 8'hFF, 8'h0F, 8'hFF, 3'd0, 1'b0, 1'b0);
        expect_out(8'h30);
        bus.in_data  = {8'h00, 8'h00, 8'h20, 8'h10};
        bus.op       = 3'd1;
        bus.acc_mode = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_data", {24'd0, bus.out_data}, 32'h0F);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_reload_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_reload_data", {24'd0, bus.out_data}, 32'h30);
        @(posedge clk);
        #1;

        // Clear aborts a frame; clear with a beat makes it beat 0
        beat(8'hFF, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'hFF, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        clear_only();
        beat(8'h01, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("clr_no_early", {31'd0, bus.out_valid}, 32'd0);
        expect_out(8'h01);
        beat(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'hFF, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'hFF, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'h02, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b1);
        beat(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        beat(8'h04, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("clr_beat0_quiet", {31'd0, bus.out_valid}, 32'd0);
        expect_out(8'h06);
        beat(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
